// File: rtl/mem_sched_pkg.sv
// Shared types and default sizing for the weighted round-robin memory port scheduler.
package mem_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_WEIGHT_W = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_scheduler_rr_pick.sv
// Cyclic priority pick: first eligible index strictly after ptr, wrapping upward.
module rr_pick
  import mem_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (eligible[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
        winner_idx   = cand;
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Packet-granular weighted round-robin arbiter muxing NUM_REQ beat streams onto one port.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_last,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][WEIGHT_W-1:0] weight,
  output logic                             port_valid,
  output logic                             port_last,
  output logic [DATA_W-1:0]                port_data,
  input  logic                             port_ready,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  sched_state_t                     state_reg, state_next;
  logic [NUM_REQ-1:0][WEIGHT_W-1:0] credit_reg, credit_next;
  logic [IDX_W-1:0]                 ptr_reg, ptr_next;
  logic [IDX_W-1:0]                 owner_reg, owner_next;
  logic [NUM_REQ-1:0]               grant_reg, grant_next;

  logic [NUM_REQ-1:0] has_credit;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win_onehot;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               reload;
  logic               last_hs;

  // A round ends once no valid, enabled requester has quota left.
  assign reload = (state_reg == IDLE) && !(|has_credit);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
      assign has_credit[gi] = req_valid[gi] && (weight[gi] != '0) && (credit_reg[gi] != '0);
      assign eligible[gi]   = req_valid[gi] && (weight[gi] != '0) &&
                              ((credit_reg[gi] != '0) || reload);
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible   (eligible),
    .ptr        (ptr_reg),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  assign busy       = (state_reg == BURST);
  assign grant      = grant_reg;
  assign port_valid = busy && req_valid[owner_reg];
  assign port_last  = busy && req_last[owner_reg];
  assign port_data  = busy ? req_data[owner_reg] : '0;
  assign req_ready  = grant_reg & {NUM_REQ{port_ready}};
  assign last_hs    = port_valid && port_ready && port_last;

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    ptr_next    = ptr_reg;
    owner_next  = owner_reg;
    grant_next  = grant_reg;
    unique case (state_reg)
      IDLE: begin
        if (reload) begin
          credit_next = weight;
        end
        if (win_any) begin
          state_next = BURST;
          grant_next = win_onehot;
          owner_next = win_idx;
        end
      end
      BURST: begin
        if (last_hs) begin
          if (credit_reg[owner_reg] != '0) begin
            credit_next[owner_reg] = credit_reg[owner_reg] - WEIGHT_W'(1);
          end
          ptr_next   = owner_reg;
          grant_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      credit_reg <= '0;
      ptr_reg    <= IDX_W'(NUM_REQ - 1);
      owner_reg  <= '0;
      grant_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      ptr_reg    <= ptr_next;
      owner_reg  <= owner_next;
      grant_reg  <= grant_next;
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Randomized scoreboard bench: a packet-level WRR model predicts the port beat stream.
module tb_mem_port_scheduler;
  localparam int NR = 4;
  localparam int DW = 64;
  localparam int WW = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [NR-1:0]          req_valid = '0;
  logic [NR-1:0]          req_last = '0;
  logic [NR-1:0][DW-1:0]  req_data = '0;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][WW-1:0]  weight;
  logic                   port_valid, port_last, busy;
  logic [DW-1:0]          port_data;
  logic                   port_ready = 1'b1;
  logic [NR-1:0]          grant;

  always #5 clk = ~clk;

  mem_port_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .WEIGHT_W(WW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data), .req_ready(req_ready),
    .weight(weight),
    .port_valid(port_valid), .port_last(port_last), .port_data(port_data), .port_ready(port_ready),
    .grant(grant), .busy(busy)
  );

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { int idx; logic [DW-1:0] data; logic last; } exp_t;

  beat_t rq[NR][$];
  int    plen[NR][$];
  exp_t  sb[$];

  logic [NR-1:0][WW-1:0] wcfg = '0;
  int    wm[NR];
  logic [NR-1:0] first_beat = '1;
  logic [NR-1:0] fire = '0;
  bit    en = 0, bubbles = 0, ready_rand = 0, mon_en = 0;
  bit    chg_arm = 0, chg_done = 0;
  logic [WW-1:0] chg_val = '0;
  int    model_ptr = NR - 1;
  int    checks = 0, passes = 0;

  // Weight[2] switches to chg_val once requester 2's first beat of the phase is taken.
  always_comb begin
    weight = wcfg;
    if (chg_arm && chg_done) weight[2] = chg_val;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  initial begin : driver
    forever begin
      @(negedge clk);
      if (!chg_arm) chg_done = 0;
      for (int i = 0; i < NR; i++) begin
        if (fire[i] && rq[i].size() > 0) begin
          first_beat[i] = rq[i][0].last;
          void'(rq[i].pop_front());
          if (i == 2 && chg_arm) chg_done = 1;
        end
        if (rq[i].size() == 0) first_beat[i] = 1'b1;
      end
      for (int i = 0; i < NR; i++) begin
        if (en && rq[i].size() > 0) begin
          req_valid[i] = !(!first_beat[i] && bubbles && $urandom_range(0, 2) == 0);
          req_data[i]  = rq[i][0].data;
          req_last[i]  = rq[i][0].last;
        end else begin
          req_valid[i] = 1'b0;
          req_data[i]  = '0;
          req_last[i]  = 1'b0;
        end
      end
      port_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1 fire = req_valid & req_ready;
    end
  end

  initial begin : monitor
    bit prev_last_hs;
    logic [NR-1:0] exp_g;
    exp_t x;
    prev_last_hs = 0;
    forever begin
      @(negedge clk); #2;
      if (!mon_en) begin
        prev_last_hs = 0;
        continue;
      end
      if (prev_last_hs) check("gap_after_last", 64'(busy), 64'(0));
      prev_last_hs = 0;
      if (!busy) begin
        check("idle_grant", 64'(grant), 64'(0));
        check("idle_handshake", 64'({port_valid, port_last, req_ready}), 64'(0));
        check("idle_data", port_data, 64'(0));
      end else if (sb.size() == 0) begin
        check("unexpected_grant", 64'({busy, grant}), 64'(0));
      end else begin
        exp_g = '0;
        exp_g[sb[0].idx] = 1'b1;
        check("grant", 64'(grant), 64'(exp_g));
        check("req_ready", 64'(req_ready), port_ready ? 64'(exp_g) : 64'(0));
        check("port_valid", 64'(port_valid), 64'(req_valid[sb[0].idx]));
        if (port_valid && port_ready) begin
          x = sb.pop_front();
          check("port_data", port_data, x.data);
          check("port_last", 64'(port_last), 64'(x.last));
          prev_last_hs = port_last;
        end
      end
    end
  end

  task automatic set_weights(input int a, input int b, input int c, input int d);
    wm[0] = a; wm[1] = b; wm[2] = c; wm[3] = d;
    for (int i = 0; i < NR; i++) wcfg[i] = WW'(wm[i]);
  endtask

  task automatic add_pkts(input int i, input int n, input int maxlen);
    beat_t nb;
    int len;
    for (int p = 0; p < n; p++) begin
      len = $urandom_range(1, maxlen);
      plen[i].push_back(len);
      for (int b = 0; b < len; b++) begin
        nb.data = {$urandom(), $urandom()};
        nb.last = (b == len - 1);
        rq[i].push_back(nb);
      end
    end
  endtask

  // Packet-level model: credits per round, reload when no valid requester has quota,
  // winner is the next eligible index after the last owner.
  task automatic model_phase();
    int rem[NR], cred[NR], w[NR], bi[NR], pi[NR];
    int win, c, len;
    bit any_cred, chg_left;
    exp_t e;
    chg_left = chg_arm;
    for (int i = 0; i < NR; i++) begin
      rem[i] = plen[i].size(); w[i] = wm[i]; cred[i] = wm[i]; bi[i] = 0; pi[i] = 0;
    end
    while (1) begin
      any_cred = 0;
      for (int i = 0; i < NR; i++)
        if (rem[i] > 0 && w[i] != 0 && cred[i] != 0) any_cred = 1;
      if (!any_cred) for (int i = 0; i < NR; i++) cred[i] = w[i];
      win = -1;
      for (int k = 1; k <= NR; k++) begin
        c = (model_ptr + k) % NR;
        if (win < 0 && rem[c] > 0 && w[c] != 0 && cred[c] != 0) win = c;
      end
      if (win < 0) break;
      len = plen[win][pi[win]];
      for (int j = 0; j < len; j++) begin
        e.idx = win; e.data = rq[win][bi[win] + j].data; e.last = rq[win][bi[win] + j].last;
        sb.push_back(e);
      end
      bi[win] += len; pi[win]++; rem[win]--; cred[win]--;
      model_ptr = win;
      if (chg_left && win == 2) begin
        w[2] = int'(chg_val);
        chg_left = 0;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) begin
      rq[i].delete();
      plen[i].delete();
    end
  endtask

  task automatic run_phase(input bit bub, input bit rr);
    int n;
    bubbles = bub; ready_rand = rr;
    repeat (3) @(negedge clk);
    model_phase();
    @(negedge clk); en = 1;
    n = 0;
    while (sb.size() > 0 && n < 5000) begin
      @(negedge clk); n++;
    end
    check("phase_drained", 64'(sb.size()), 64'(0));
    sb.delete();
    repeat (20) @(negedge clk);
    en = 0;
    @(negedge clk); #3;
    clear_queues();
    chg_arm = 0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    beat_t nb;
    int n;
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_busy_port", 64'({busy, port_valid, port_last, req_ready}), 64'(0));
    check("rst_data", port_data, 64'(0));
    reset = 1; mon_en = 1;

    set_weights(1, 1, 1, 1);
    for (int i = 0; i < NR; i++) add_pkts(i, 2, 1);
    run_phase(0, 0);

    set_weights(3, 1, 0, 0);
    add_pkts(0, 7, 2); add_pkts(1, 3, 2); add_pkts(2, 3, 2);
    run_phase(0, 1);

    set_weights(1, 1, 1, 1);
    add_pkts(2, 1, 1);
    for (int b = 0; b < 3; b++) begin
      nb.data = {$urandom(), $urandom()}; nb.last = 1'b0; rq[2].push_back(nb);
    end
    rq[2][0].last = 1'b0; rq[2][3].last = 1'b1; plen[2][0] = 4;
    run_phase(0, 1);

    set_weights(1, 1, 1, 1);
    add_pkts(1, 2, 4); add_pkts(0, 3, 2);
    run_phase(1, 1);

    set_weights(1, 1, 2, 1);
    chg_val = 4'd5; chg_arm = 1;
    add_pkts(0, 4, 2); add_pkts(1, 4, 2); add_pkts(2, 9, 2); add_pkts(3, 4, 2);
    run_phase(0, 1);

    for (int r = 0; r < 8; r++) begin
      set_weights($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < NR; i++) add_pkts(i, $urandom_range(0, 4), 4);
      run_phase($urandom_range(0, 1), $urandom_range(0, 1));
    end

    // Reset in the middle of a 4-beat burst from requester 2.
    mon_en = 0; bubbles = 0; ready_rand = 0;
    set_weights(1, 1, 1, 1);
    for (int b = 0; b < 4; b++) begin
      nb.data = {$urandom(), $urandom()}; nb.last = (b == 3); rq[2].push_back(nb);
    end
    repeat (2) @(negedge clk);
    en = 1;
    n = 0;
    while (rq[2].size() != 3 && n < 200) begin
      @(negedge clk); #3; n++;
    end
    check("rst_reached_beat2", 64'(rq[2].size()), 64'(3));
    check("pre_rst_busy", 64'({busy, port_valid}), 64'(2'b11));
    reset = 0;
    #1;
    check("midrst_grant", 64'(grant), 64'(0));
    check("midrst_port", 64'({busy, port_valid, port_last, req_ready}), 64'(0));
    check("midrst_data", port_data, 64'(0));
    en = 0;
    clear_queues();
    repeat (2) @(negedge clk);
    reset = 1; model_ptr = NR - 1; mon_en = 1;

    set_weights(1, 1, 1, 1);
    for (int i = 1; i < NR; i++) add_pkts(i, 2, 2);
    add_pkts(0, 1, 1);
    run_phase(0, 0);

    set_weights(0, 0, 0, 0);
    for (int i = 0; i < NR; i++) add_pkts(i, 2, 2);
    run_phase(0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_scheduler.md
MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the port.
REQ-002 Parameter DATA_W, default 64: beat data width.
REQ-003 Parameter WEIGHT_W, default 4: weight and credit width.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-007 req_last  input  NUM_REQ  per-requester last beat of packet.
REQ-008 req_data  input  NUM_REQ x DATA_W  per-requester beat data.
REQ-009 req_ready  output  NUM_REQ  per-requester beat accept.
REQ-010 weight  input  NUM_REQ x WEIGHT_W  packets per round per requester; 0 disables the requester.
REQ-011 port_valid, port_last  output  1 each  shared port beat valid and last.
REQ-012 port_data  output  DATA_W  shared port beat data.
REQ-013 port_ready  input  1  shared port accept.
REQ-014 grant  output  NUM_REQ  one-hot current owner, registered.
REQ-015 busy  output  1  high while in BURST.

Function
REQ-016 FSM states SHALL be IDLE and BURST; reset state IDLE.
REQ-017 eligible[i] = req_valid[i] & (weight[i]!=0) & (credit[i]!=0 | reload).
REQ-018 reload SHALL assert in IDLE when no requester has req_valid & nonzero weight & nonzero credit; all credits then load from weight in that cycle.
REQ-019 In IDLE, with any eligible bit set, the winner SHALL be the first eligible index after ptr, searched cyclically upward; grant registers next cycle and FSM enters BURST (1-cycle grant latency).
REQ-020 In BURST: port_valid=req_valid[owner], port_last=req_last[owner], port_data=req_data[owner], req_ready[owner]=port_ready; every other req_ready SHALL be 0.
REQ-021 Ownership SHALL hold until a beat with port_valid & port_ready & port_last; valid dropping mid-packet SHALL NOT release the port.
REQ-022 On the last-beat handshake: credit[owner] decrements by 1, ptr takes the owner index, grant clears, FSM returns to IDLE.
REQ-023 One idle cycle SHALL separate consecutive packets, including back-to-back packets from the same requester.
REQ-024 Weight changes SHALL take effect only at the next reload; credits never underflow below 0.
REQ-025 With all weights 0, grant SHALL stay 0 indefinitely.
REQ-026 In IDLE, port_valid, port_last and all req_ready SHALL be 0, and port_data SHALL be 0.

Reset
REQ-027 Asserting reset SHALL immediately clear grant, busy, port_valid, port_last, port_data and req_ready, set all credits to 0 and set ptr to NUM_REQ-1.
REQ-028 Reset asserted mid-burst SHALL abandon the packet; after release the first arbitration performs a reload and favours index 0.

Structure
REQ-029 Package mem_sched_pkg SHALL hold the state enum and the default parameter constants.
REQ-030 Sub-module rr_pick (combinational, inputs eligible and ptr, outputs a one-hot winner and its index) SHALL perform the cyclic search.

Verification
REQ-031 After reset, req_valid=4'b1111 and weights {1,1,1,1} with 1-beat packets -> grants 0,1,2,3,0 on every second cycle.
REQ-032 Weights {3,1,0,0}, requesters 0 and 1 continuously valid -> per round, three packets from 0 and one from 1; requester 2 is never granted.
REQ-033 4-beat packet on requester 2 with port_ready low on beats 2-3 -> grant held; exactly 4 beats with last on the 4th; then IDLE.
REQ-034 Requester 1 drops valid for 3 cycles mid-packet while requester 0 is valid -> grant stays on 1 and port_valid is 0 during the gap.
REQ-035 Reset pulsed during beat 2 of a burst -> grant and port_valid are 0 in the same cycle; after release the first grant goes to the lowest valid index.
REQ-036 Weight 2 changed to 5 mid-round -> the old quota finishes, and 5 packets are granted in the round after the reload.
